// File: rtl/router_egress_arb.sv
// Round-robin egress arbiter: moves whole packets (header, L payload bytes, parity) from three FWFT FIFOs onto one link.
// Define ROUTER_EGRESS_PARITY_CHK_EN to add the XOR parity checker that drives parity_err.

module router_egress_lane #(
  parameter int         DATA_W = 8,
  parameter logic [1:0] IDX    = 2'd0
) (
  input  logic              active,
  input  logic [1:0]        grant,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] dout,
  input  logic              egress_ready,
  output logic              lane_valid,
  output logic [DATA_W-1:0] lane_data,
  output logic              read_enb
);
  logic sel;

  assign sel        = active & (grant == IDX);
  assign lane_valid = sel & ~fifo_empty;
  assign lane_data  = sel ? dout : '0;
  assign read_enb   = lane_valid & egress_ready;
endmodule

module router_egress_arb #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic [DATA_W-1:0] dout_0,
  input  logic [DATA_W-1:0] dout_1,
  input  logic [DATA_W-1:0] dout_2,
  output logic              read_enb_0,
  output logic              read_enb_1,
  output logic              read_enb_2,
  output logic [DATA_W-1:0] egress_data,
  output logic              egress_valid,
  input  logic              egress_ready,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              pkt_done,
  output logic              parity_err
);
  localparam int NUM_LANES = 3;

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, PARITY} state_t;

  state_t                              state;
  logic [1:0]                          last_grant;
  logic [5:0]                          cnt;
  logic                                active, xfer, pick_vld;
  logic [1:0]                          pick;
  logic [NUM_LANES-1:0]                empty_vec, lane_valid, rd_vec;
  logic [NUM_LANES-1:0][DATA_W-1:0]    dout_vec, lane_data;
  logic [5:0]                          hdr_len;

  assign empty_vec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign dout_vec  = {dout_2, dout_1, dout_0};
  assign active    = (state != IDLE);
  assign busy      = active;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    router_egress_lane #(.DATA_W(DATA_W), .IDX(2'(i))) u_lane (
      .active       (active),
      .grant        (grant),
      .fifo_empty   (empty_vec[i]),
      .dout         (dout_vec[i]),
      .egress_ready (egress_ready),
      .lane_valid   (lane_valid[i]),
      .lane_data    (lane_data[i]),
      .read_enb     (rd_vec[i])
    );
  end

  // Non-selected lanes contribute zero, so an OR-reduce is the output mux.
  always_comb begin
    egress_data = '0;
    for (int i = 0; i < NUM_LANES; i++) egress_data = egress_data | lane_data[i];
  end

  assign egress_valid = |lane_valid;
  assign xfer         = egress_valid & egress_ready;
  assign read_enb_0   = rd_vec[0];
  assign read_enb_1   = rd_vec[1];
  assign read_enb_2   = rd_vec[2];
  assign hdr_len      = egress_data[7:2];

  function automatic logic [1:0] rr_idx(input logic [1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NUM_LANES;
    return 2'(s);
  endfunction

  // Scan furthest candidate first so the nearest non-empty FIFO after last_grant wins.
  always_comb begin
    pick     = 2'b11;
    pick_vld = 1'b0;
    for (int k = NUM_LANES; k >= 1; k--) begin
      if (!empty_vec[rr_idx(last_grant, k)]) begin
        pick     = rr_idx(last_grant, k);
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= 2'b11;
      last_grant <= 2'd2;
      cnt        <= '0;
      pkt_done   <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      case (state)
        IDLE: if (pick_vld) begin
          grant <= pick;
          state <= HEADER;
        end
        HEADER: if (xfer) begin
          cnt   <= hdr_len;
          state <= (hdr_len != 6'd0) ? PAYLOAD : PARITY;
        end
        PAYLOAD: if (xfer) begin
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) state <= PARITY;
        end
        PARITY: if (xfer) begin
          state      <= IDLE;
          last_grant <= grant;
          grant      <= 2'b11;
          pkt_done   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROUTER_EGRESS_PARITY_CHK_EN
  logic [DATA_W-1:0] acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc        <= '0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= (state == PARITY) & xfer & (egress_data != acc);
      if (state == IDLE)                  acc <= '0;
      else if (xfer && state != PARITY)   acc <= acc ^ egress_data;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_egress_arb.sv
// Randomized scoreboard bench for router_egress_arb: FIFO models feed packets, a round-robin reference predicts the egress stream.

module tb_router_egress_arb;
  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic [7:0] dout_0, dout_1, dout_2;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic [7:0] egress_data;
  logic       egress_valid, egress_ready;
  logic [1:0] grant;
  logic       busy, pkt_done, parity_err;

  always #5 clk = ~clk;

  router_egress_arb #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .dout_0(dout_0), .dout_1(dout_1), .dout_2(dout_2),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .egress_data(egress_data), .egress_valid(egress_valid), .egress_ready(egress_ready),
    .grant(grant), .busy(busy), .pkt_done(pkt_done), .parity_err(parity_err)
  );

  typedef struct {int fifo; logic [7:0] data; bit last; bit perr;} exp_t;

  exp_t       exp_q[$];
  logic [7:0] fq[3][$];
  logic [7:0] stage_b[$];
  int         stage_f[$], stage_n[$];
  int         pq[3][$];
  bit         mask[3], pop_req[3];
  int         checks = 0, failures = 0;
  int         model_last = 2;
  int         xfers = 0;
  bit         mon_en = 0, stall_en = 0;
  bit         mid_pkt = 0, pend_done = 0, pend_perr = 0, busy_next = 0, hold_prev = 0;
  int         cur_fifo = 0;
  logic [7:0] prev_data;
  int         rdy_ctr = 0, msk_ctr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    fifo_empty_0 = (fq[0].size() == 0) || mask[0];
    fifo_empty_1 = (fq[1].size() == 0) || mask[1];
    fifo_empty_2 = (fq[2].size() == 0) || mask[2];
    dout_0 = (fq[0].size() > 0) ? fq[0][0] : 8'h00;
    dout_1 = (fq[1].size() > 0) ? fq[1][0] : 8'h00;
    dout_2 = (fq[2].size() > 0) ? fq[2][0] : 8'h00;
  endtask

  task automatic flush();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      fq[i].delete(); mask[i] = 0; pop_req[i] = 0;
    end
    mid_pkt = 0; pend_done = 0; busy_next = 0; hold_prev = 0;
    rdy_ctr = 0; msk_ctr = 0;
  endtask

  // One clock: apply the pops seen by the monitor, then redraw ready/empty-stall stimulus.
  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      if (pop_req[i] && fq[i].size() > 0) fq[i].delete(0);
      pop_req[i] = 0;
    end
    if (rdy_ctr > 0) begin
      egress_ready = 1'b0; rdy_ctr--;
    end else if (stall_en && $urandom_range(0, 7) == 0) begin
      egress_ready = 1'b0; rdy_ctr = 2;
    end else egress_ready = 1'b1;
    for (int i = 0; i < 3; i++) mask[i] = 0;
    if (mid_pkt) begin
      if (msk_ctr > 0) begin
        mask[cur_fifo] = 1; msk_ctr--;
      end else if (stall_en && $urandom_range(0, 9) == 0) begin
        mask[cur_fifo] = 1; msk_ctr = 1;
      end
    end else msk_ctr = 0;
    drive();
  endtask

  task automatic add_pkt(input int f, input int len, input bit bad);
    logic [7:0] b, acc;
    b = {6'(len), 2'($urandom)};
    acc = b;
    stage_b.push_back(b);
    for (int j = 0; j < len; j++) begin
      b = 8'($urandom); acc ^= b; stage_b.push_back(b);
    end
    if (bad) acc ^= 8'(1 << $urandom_range(0, 7));
    stage_b.push_back(acc);
    stage_f.push_back(f);
    stage_n.push_back(len + 2);
  endtask

  task automatic add_bytes(input int f, input logic [31:0] w, input int n);
    for (int j = 0; j < n; j++) stage_b.push_back(w[31-8*j -: 8]);
    stage_f.push_back(f);
    stage_n.push_back(n);
  endtask

  // Reference: whole packets, served round-robin from the FIFO after the last one served.
  task automatic commit(output int first);
    int st[$];
    int off, p, f, n, left;
    logic [7:0] acc;
    bit perr;
    exp_t e;
    for (int i = 0; i < 3; i++) pq[i].delete();
    off = 0; first = -1;
    for (int i = 0; i < stage_f.size(); i++) begin
      pq[stage_f[i]].push_back(i);
      st.push_back(off);
      for (int j = 0; j < stage_n[i]; j++) fq[stage_f[i]].push_back(stage_b[off+j]);
      off += stage_n[i];
    end
    left = stage_f.size();
    while (left > 0) begin
      for (int k = 1; k <= 3; k++) begin
        f = (model_last + k) % 3;
        if (pq[f].size() > 0) begin
          p = pq[f].pop_front();
          n = stage_n[p];
          acc = 8'h00;
          for (int j = 0; j < n - 1; j++) acc ^= stage_b[st[p]+j];
`ifdef ROUTER_EGRESS_PARITY_CHK_EN
          perr = (stage_b[st[p]+n-1] != acc);
`else
          perr = 0;
`endif
          for (int j = 0; j < n; j++) begin
            e.fifo = f; e.data = stage_b[st[p]+j]; e.last = (j == n - 1); e.perr = perr;
            exp_q.push_back(e);
          end
          model_last = f;
          if (first < 0) first = f;
          left--;
          break;
        end
      end
    end
    stage_b.delete(); stage_f.delete(); stage_n.delete();
  endtask

  task automatic run_phase();
    int first, n;
    step();
    commit(first);
    drive();
    step();
    chk("arb_grant", 32'(grant), 32'(first));
    chk("arb_busy", 32'(busy), 1);
    n = 0;
    while ((exp_q.size() > 0 || pend_done) && n < 3000) begin
      step(); n++;
    end
    if (n >= 3000) begin
      checks++; failures++;
      $display("FAIL drain_timeout: got %0d bytes left expected 0", exp_q.size());
      flush(); drive();
    end
  endtask

  task automatic rand_phase(input int maxlen);
    int np;
    np = $urandom_range(1, 5);
    for (int i = 0; i < np; i++)
      add_pkt($urandom_range(0, 2), $urandom_range(0, maxlen), $urandom_range(0, 3) == 0);
    run_phase();
  endtask

  task automatic reset_mid_packet();
    int first, n, x0;
    step();
    add_pkt(1, 6, 0);
    commit(first);
    drive();
    x0 = xfers; n = 0;
    while (xfers < x0 + 3 && n < 500) begin
      step(); n++;
    end
    chk("rst_reached_payload", 32'(xfers >= x0 + 3), 1);
    mon_en = 0;
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(egress_valid), 0);
    chk("rst_read_enb", {read_enb_2, read_enb_1, read_enb_0}, 0);
    chk("rst_data", 32'(egress_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant), 3);
    chk("rst_pkt_done", 32'(pkt_done), 0);
    flush();
    model_last = 2;
    drive();
    step(); step();
    chk("rst_hold_pkt_done", 32'(pkt_done), 0);
    rst = 1'b1;
    mon_en = 1;
  endtask

  always @(negedge clk) begin
    logic [2:0] re;
    exp_t e;
    if (mon_en) begin
      re = {read_enb_2, read_enb_1, read_enb_0};
      if (pend_done) begin
        chk("pkt_done", 32'(pkt_done), 1);
        chk("parity_err", 32'(parity_err), 32'(pend_perr));
        chk("bubble_busy", 32'(busy), 0);
        chk("bubble_grant", 32'(grant), 3);
        pend_done = 0;
        busy_next = (exp_q.size() > 0);
      end else begin
        chk("no_pkt_done", {pkt_done, parity_err}, 0);
        if (busy_next) begin
          chk("next_busy", 32'(busy), 1);
          chk("next_grant", 32'(grant), 32'(exp_q[0].fifo));
          busy_next = 0;
        end
      end
      if (mid_pkt && mask[cur_fifo]) begin
        chk("empty_valid", 32'(egress_valid), 0);
        chk("empty_grant", 32'(grant), 32'(cur_fifo));
      end
      if (hold_prev && egress_valid) chk("hold_data", 32'(egress_data), 32'(prev_data));
      hold_prev = egress_valid && !egress_ready;
      prev_data = egress_data;
      if (egress_valid && egress_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_xfer: got byte %0h from grant %0d expected none", egress_data, grant);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_grant", 32'(grant), 32'(e.fifo));
          chk("xfer_data", 32'(egress_data), 32'(e.data));
          chk("xfer_read_enb", 32'(re), 32'(1 << e.fifo));
          if (e.last) begin
            mid_pkt = 0; pend_done = 1; pend_perr = e.perr;
          end else if (!mid_pkt) begin
            mid_pkt = 1; cur_fifo = e.fifo;
          end
        end
        for (int i = 0; i < 3; i++) if (re[i]) pop_req[i] = 1;
        xfers++;
      end else begin
        chk("no_read", 32'(re), 0);
      end
    end
  end

  initial begin
    rst = 1'b0;
    egress_ready = 1'b1;
    flush();
    drive();
    fifo_empty_0 = 1'b0;
    dout_0 = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(egress_valid), 0);
    chk("reset_read_enb", {read_enb_2, read_enb_1, read_enb_0}, 0);
    chk("reset_data", 32'(egress_data), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_grant", 32'(grant), 3);
    chk("reset_done_perr", {pkt_done, parity_err}, 0);
    drive();
    rst = 1'b1;
    mon_en = 1;

    add_bytes(1, 32'h09AABB18, 4);
    run_phase();

    stall_en = 1;
    for (int i = 0; i < 10; i++) rand_phase(7);
    add_pkt(2, 63, 0);
    run_phase();

    add_bytes(0, 32'h05010000, 3);
    run_phase();

    reset_mid_packet();

    stall_en = 0;
    add_pkt(0, 0, 0); add_pkt(1, 0, 0); add_pkt(2, 0, 0); add_pkt(0, 0, 0);
    run_phase();

    stall_en = 1;
    for (int i = 0; i < 8; i++) rand_phase(12);

    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
